prod_norm_round: RTL and testbench

Pipelined normalize-and-round stage that sits directly downstream of the registered 25×25 multiplier and consumes its 50-bit unsigned product. It locates the leading one and normalizes the product to a 24-bit significand with explicit leading bit. It rounds to nearest-even and adjusts a signed exponent that travels alongside the product. A valid/ready handshake on both sides lets it sit between the multiplier and a stalling consumer.

---
 rtl/norm_pkg.sv | 8 +
 rtl/prod_norm_round_if.sv | 28 ++
 rtl/prod_norm_round_lzc50.sv | 18 +
 rtl/prod_norm_round.sv | 135 +++++++++++++
 tb/tb_prod_norm_round.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/norm_pkg.sv
// Shared widths and constants for the product normalize/round stage.
package norm_pkg;
  localparam int PROD_W  = 50;
  localparam int MANT_W  = 24;
  localparam int EXP_W   = 12;
  localparam int EXP_ADJ = 46;
  localparam int LZC_W   = 6;
endpackage

// File: rtl/prod_norm_round_if.sv
// Upstream (product) and downstream (result) valid/ready channels of prod_norm_round.
interface prod_norm_round_if;
  import norm_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [PROD_W-1:0]        prod;
  logic signed [EXP_W-1:0]  exp_in;
  logic                     sign_in;

  logic                     out_valid;
  logic                     out_ready;
  logic [MANT_W-1:0]        mant;
  logic signed [EXP_W-1:0]  exp_out;
  logic                     sign_out;
  logic                     zero;
  logic                     inexact;

  modport master (
    output in_valid, prod, exp_in, sign_in, out_ready,
    input  in_ready, out_valid, mant, exp_out, sign_out, zero, inexact
  );

  modport slave (
    input  in_valid, prod, exp_in, sign_in, out_ready,
    output in_ready, out_valid, mant, exp_out, sign_out, zero, inexact
  );
endinterface

// File: rtl/prod_norm_round_lzc50.sv
// Leading-one index of a 50-bit vector plus an all-zero flag (combinational).
module lzc50
  import norm_pkg::*;
(
  input  logic [PROD_W-1:0] vec,
  output logic [LZC_W-1:0]  idx,
  output logic              zero
);

  always_comb begin
    idx  = '0;
    zero = ~|vec;
    for (int i = 0; i < PROD_W; i++) begin
      if (vec[i]) idx = LZC_W'(i);
    end
  end

endmodule

// File: rtl/prod_norm_round.sv
// Two-stage normalize-and-round of a 50-bit product with valid/ready on both sides.
// Define PNR_RNE_EN for round-to-nearest-even; otherwise the significand is truncated.
module prod_norm_round
  import norm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  prod_norm_round_if.slave bus
);

`ifdef PNR_RNE_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  localparam logic [LZC_W-1:0]  TOP_IDX  = LZC_W'(MANT_W - 1);
  localparam logic [MANT_W-1:0] MANT_ONE = {1'b1, {(MANT_W-1){1'b0}}};

  // Result has one extra bit so a rounding carry out of the significand is visible.
  function automatic logic [MANT_W:0] round_mant(input logic [MANT_W-1:0] t,
                                                 input logic guard, input logic sticky);
    logic inc;
    inc = RNE_EN & guard & (sticky | t[0]);
    return {1'b0, t} + (MANT_W+1)'(inc);
  endfunction

  function automatic logic signed [EXP_W-1:0] exp_adjust(input logic signed [EXP_W-1:0] e,
                                                         input logic [LZC_W-1:0] p,
                                                         input logic c);
    return e + $signed(EXP_W'(p)) - $signed(EXP_W'(EXP_ADJ)) + $signed(EXP_W'(c));
  endfunction

  logic                    vld_p1, vld_p2;
  logic                    s1_adv, s2_adv;
  logic [PROD_W-1:0]       prod_p1;
  logic signed [EXP_W-1:0] exp_p1;
  logic                    sign_p1;
  logic [LZC_W-1:0]        lead_p1;
  logic                    zero_p1;
  logic [LZC_W-1:0]        lead_p0;
  logic                    zero_p0;

  logic [MANT_W-1:0]       mant_p2;
  logic signed [EXP_W-1:0] exp_p2;
  logic                    sign_p2, zero_p2, inexact_p2;

  logic [MANT_W-1:0]       mant_nxt;
  logic signed [EXP_W-1:0] exp_nxt;
  logic                    inexact_nxt;
  logic [LZC_W-1:0]        sh;
  logic [PROD_W-1:0]       t_full, mask;
  logic                    guard, sticky;
  logic [MANT_W:0]         rnd;

  assign s2_adv       = ~vld_p2 | bus.out_ready;
  assign s1_adv       = ~vld_p1 | s2_adv;
  assign bus.in_ready = s1_adv;

  lzc50 u_lzc (
    .vec  (bus.prod),
    .idx  (lead_p0),
    .zero (zero_p0)
  );

  // ---- stage 1: capture operands and leading-one position ----
  always_ff @(posedge clk) begin
    if (bus.in_valid && s1_adv) begin
      prod_p1 <= bus.prod;
      exp_p1  <= bus.exp_in;
      sign_p1 <= bus.sign_in;
      lead_p1 <= lead_p0;
      zero_p1 <= zero_p0;
    end
  end

  always_comb begin
    mant_nxt    = '0;
    exp_nxt     = '0;
    inexact_nxt = 1'b0;
    sh          = '0;
    t_full      = '0;
    mask        = '0;
    guard       = 1'b0;
    sticky      = 1'b0;
    rnd         = '0;
    if (zero_p1) begin
      mant_nxt = '0;
    end else if (lead_p1 <= TOP_IDX) begin
      mant_nxt = MANT_W'(prod_p1 << (TOP_IDX - lead_p1));
      exp_nxt  = exp_adjust(exp_p1, lead_p1, 1'b0);
    end else begin
      sh          = lead_p1 - TOP_IDX;
      t_full      = prod_p1 >> sh;
      guard       = prod_p1[sh - LZC_W'(1)];
      mask        = (PROD_W'(1) << (sh - LZC_W'(1))) - PROD_W'(1);
      sticky      = |(prod_p1 & mask);
      rnd         = round_mant(MANT_W'(t_full), guard, sticky);
      mant_nxt    = rnd[MANT_W] ? MANT_ONE : rnd[MANT_W-1:0];
      exp_nxt     = exp_adjust(exp_p1, lead_p1, rnd[MANT_W]);
      inexact_nxt = guard | sticky;
    end
  end

  // ---- stage 2: shifted, rounded result registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      mant_p2    <= '0;
      exp_p2     <= '0;
      sign_p2    <= 1'b0;
      zero_p2    <= 1'b0;
      inexact_p2 <= 1'b0;
    end else begin
      if (s1_adv) vld_p1 <= bus.in_valid;
      if (s2_adv) vld_p2 <= vld_p1;
      if (s2_adv && vld_p1) begin
        mant_p2    <= mant_nxt;
        exp_p2     <= exp_nxt;
        sign_p2    <= sign_p1;
        zero_p2    <= zero_p1;
        inexact_p2 <= inexact_nxt;
      end
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.mant      = mant_p2;
  assign bus.exp_out   = exp_p2;
  assign bus.sign_out  = sign_p2;
  assign bus.zero      = zero_p2;
  assign bus.inexact   = inexact_p2;

endmodule

// File: tb/tb_prod_norm_round.sv
// Directed bench for prod_norm_round; expectations follow the PNR_RNE_EN build setting.
module tb_prod_norm_round;
  import norm_pkg::*;

`ifdef PNR_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prod_norm_round_if bus();
  prod_norm_round dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [PROD_W-1:0] prod;
    logic [EXP_W-1:0]  e;
    logic              s;
    logic [MANT_W-1:0] m;
    logic [EXP_W-1:0]  eo;
    logic              z;
    logic              ix;
  } vec_t;

  vec_t tv[11];

  function automatic vec_t mk(input logic [PROD_W-1:0] p, input logic [EXP_W-1:0] e,
                              input logic s, input logic [MANT_W-1:0] m,
                              input logic [EXP_W-1:0] eo, input logic z, input logic ix);
    vec_t v;
    v.prod = p; v.e = e; v.s = s; v.m = m; v.eo = eo; v.z = z; v.ix = ix;
    return v;
  endfunction

  task automatic load_vectors;
    tv[0]  = mk(50'd1 << 46, 12'd127, 1'b0, 24'h800000, 12'd127, 1'b0, 1'b0);
    tv[1]  = mk(50'hFFFF_FE00_0001, 12'd0, 1'b1, 24'hFFFFFE, 12'd1, 1'b0, 1'b1);
    tv[2]  = mk((50'd1 << 47) + (50'd1 << 23), 12'd0, 1'b0, 24'h800000, 12'd1, 1'b0, 1'b1);
    tv[3]  = mk((50'd1 << 47) + (50'd1 << 24) + (50'd1 << 23), 12'd0, 1'b0,
                RNE ? 24'h800002 : 24'h800001, 12'd1, 1'b0, 1'b1);
    tv[4]  = mk((50'd1 << 48) - 50'd1, 12'd0, 1'b0,
                RNE ? 24'h800000 : 24'hFFFFFF, RNE ? 12'd2 : 12'd1, 1'b0, 1'b1);
    tv[5]  = mk(50'd0, 12'h055, 1'b1, 24'h000000, 12'h000, 1'b1, 1'b0);
    tv[6]  = mk(50'd5, 12'd0, 1'b0, 24'hA00000, 12'hFD4, 1'b0, 1'b0);
    tv[7]  = mk(50'd1 << 49, 12'h7FE, 1'b0, 24'h800000, 12'h801, 1'b0, 1'b0);
    tv[8]  = mk((50'd1 << 23) + 50'd1, 12'd0, 1'b0, 24'h800001, 12'hFE9, 1'b0, 1'b0);
    tv[9]  = mk((50'd1 << 24) + 50'd1, 12'd0, 1'b0, 24'h800000, 12'hFEA, 1'b0, 1'b1);
    tv[10] = mk((50'd1 << 24) + 50'd3, 12'd0, 1'b0,
                RNE ? 24'h800002 : 24'h800001, 12'hFEA, 1'b0, 1'b1);
  endtask

  task automatic drive(input vec_t v, input logic valid);
    bus.in_valid = valid;
    bus.prod     = v.prod;
    bus.exp_in   = v.e;
    bus.sign_in  = v.s;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(tv[0], 1'b0);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.out_valid, bus.mant, bus.exp_out, bus.sign_out, bus.zero, bus.inexact} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b m=%h e=%h s=%b z=%b ix=%b want all zero",
               bus.out_valid, bus.mant, bus.exp_out, bus.sign_out, bus.zero, bus.inexact);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_vectors;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      drive(tv[k], 1'b1);
      @(posedge clk); #1;
      drive(tv[k], 1'b0);
      n_vec++;
      if (bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL latency_vec%0d out_valid got %b want 0 one edge after accept", k, bus.out_valid);
      end
      @(posedge clk); #1;
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.mant !== tv[k].m || bus.exp_out !== tv[k].eo ||
          bus.sign_out !== tv[k].s || bus.zero !== tv[k].z || bus.inexact !== tv[k].ix) begin
        n_err++;
        $display("FAIL vec%0d got v=%b m=%h e=%h s=%b z=%b ix=%b want v=1 m=%h e=%h s=%b z=%b ix=%b",
                 k, bus.out_valid, bus.mant, bus.exp_out, bus.sign_out, bus.zero, bus.inexact,
                 tv[k].m, tv[k].eo, tv[k].s, tv[k].z, tv[k].ix);
      end
    end
  endtask

  task automatic test_back_to_back;
    int bb[4];
    bb = '{0, 1, 6, 8};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(tv[bb[k]], 1'b1);
      else       drive(tv[0], 1'b0);
      n_vec++;
      if (bus.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_in_ready cycle%0d got %b want 1", k, bus.in_ready);
      end
      @(posedge clk); #1;
      if (k >= 1) begin
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.mant !== tv[bb[k-1]].m || bus.exp_out !== tv[bb[k-1]].eo) begin
          n_err++;
          $display("FAIL b2b_out%0d got v=%b m=%h e=%h want v=1 m=%h e=%h", k - 1,
                   bus.out_valid, bus.mant, bus.exp_out, tv[bb[k-1]].m, tv[bb[k-1]].eo);
        end
      end
    end
    drive(tv[0], 1'b0);
    @(posedge clk); #1;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure;
    int bp[4];
    int i;
    int recv;
    logic acc;
    bp = '{0, 1, 6, 8};
    i = 0;
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (i < 4) drive(tv[bp[i]], 1'b1);
      #1;
      acc = bus.in_valid & bus.in_ready;
      if (cyc >= 3) begin
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.mant !== tv[bp[0]].m || bus.exp_out !== tv[bp[0]].eo) begin
          n_err++;
          $display("FAIL bp_hold cycle%0d got v=%b m=%h e=%h want v=1 m=%h e=%h", cyc,
                   bus.out_valid, bus.mant, bus.exp_out, tv[bp[0]].m, tv[bp[0]].eo);
        end
      end
      @(posedge clk); #1;
      if (acc) i++;
    end
    n_vec++;
    if (i != 2) begin
      n_err++;
      $display("FAIL bp_accepted got %0d want 2", i);
    end
    n_vec++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_in_ready got %b want 0", bus.in_ready);
    end

    bus.out_ready = 1'b1;
    recv = 0;
    for (int cyc = 0; cyc < 20 && recv < 4; cyc++) begin
      if (i < 4) drive(tv[bp[i]], 1'b1);
      else       drive(tv[0], 1'b0);
      #1;
      acc = bus.in_valid & bus.in_ready;
      if (bus.out_valid === 1'b1) begin
        n_vec++;
        if (bus.mant !== tv[bp[recv]].m || bus.exp_out !== tv[bp[recv]].eo ||
            bus.sign_out !== tv[bp[recv]].s || bus.inexact !== tv[bp[recv]].ix) begin
          n_err++;
          $display("FAIL bp_out%0d got m=%h e=%h s=%b ix=%b want m=%h e=%h s=%b ix=%b", recv,
                   bus.mant, bus.exp_out, bus.sign_out, bus.inexact,
                   tv[bp[recv]].m, tv[bp[recv]].eo, tv[bp[recv]].s, tv[bp[recv]].ix);
        end
        recv++;
      end
      @(posedge clk); #1;
      if (acc) i++;
    end
    drive(tv[0], 1'b0);
    n_vec++;
    if (recv != 4 || i != 4) begin
      n_err++;
      $display("FAIL bp_count got recv=%0d sent=%0d want recv=4 sent=4", recv, i);
    end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_no_dup out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_midstream;
    bus.out_ready = 1'b1;
    drive(tv[1], 1'b1);
    @(posedge clk); #1;
    drive(tv[7], 1'b1);
    @(posedge clk); #1;
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.sign_out !== 1'b1) begin
      n_err++;
      $display("FAIL mid_prefill got v=%b s=%b want v=1 s=1", bus.out_valid, bus.sign_out);
    end
    rst = 1'b1;
    drive(tv[4], 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(tv[9], 1'b0);
    n_vec++;
    if ({bus.out_valid, bus.mant, bus.exp_out, bus.sign_out, bus.zero, bus.inexact} !== '0) begin
      n_err++;
      $display("FAIL mid_reset got v=%b m=%h e=%h s=%b z=%b ix=%b want all zero",
               bus.out_valid, bus.mant, bus.exp_out, bus.sign_out, bus.zero, bus.inexact);
    end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_in_ready got %b want 1", bus.in_ready);
    end
    drive(tv[9], 1'b1);
    @(posedge clk); #1;
    drive(tv[9], 1'b0);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_flushed out_valid got %b want 0", bus.out_valid);
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.mant !== tv[9].m || bus.exp_out !== tv[9].eo ||
        bus.inexact !== tv[9].ix || bus.sign_out !== tv[9].s) begin
      n_err++;
      $display("FAIL mid_after got v=%b m=%h e=%h ix=%b want v=1 m=%h e=%h ix=%b",
               bus.out_valid, bus.mant, bus.exp_out, bus.inexact, tv[9].m, tv[9].eo, tv[9].ix);
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_tail out_valid got %b want 0", bus.out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    load_vectors();
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
